// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode handshake bundle.
// master: fetch_unit side. slave: memory / branch unit / decode side.
// Signals:
//   imem_req_valid/ready/addr  word read request toward instruction memory
//   imem_rsp_valid/data        in-order read data, never back-pressured
//   redirect_valid/pc          restart fetch at a new PC
//   instr_valid/ready          head-of-buffer handshake toward decode
//   instr/instr_pc             instruction word and its address
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        output instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, in-order imem reads, instruction buffer to decode.
// Ports: clk, rst_n (sync, active low), bus (fetch_unit_if.master).
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [OW-1:0] MAXO_C  = OW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] ALAST   = AW'(FIFO_DEPTH - 1);
    localparam logic [QW-1:0] QLAST   = QW'(MAX_OUTSTANDING - 1);

    logic [31:0]   r_pc;
    logic [OW-1:0] r_outs;
    logic [OW-1:0] r_disc;
    logic [CW-1:0] r_cnt;
    logic          r_req_valid;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [QW-1:0] r_qwr;
    logic [QW-1:0] r_qrd;
    logic [31:0]   r_fdata [FIFO_DEPTH];
    logic [31:0]   r_fpc   [FIFO_DEPTH];
    logic [31:0]   r_qpc   [MAX_OUTSTANDING];

    logic          w_fire;
    logic          w_rsp;
    logic          w_redir;
    logic          w_stale;
    logic          w_push;
    logic          w_pop;
    logic [OW-1:0] w_outs_n;
    logic [OW-1:0] w_disc_n;
    logic [CW-1:0] w_cnt_n;
    logic [31:0]   w_pc_n;
    logic [31:0]   w_live_n;
    logic          w_req_n;

    function automatic logic [AW-1:0] finc(input logic [AW-1:0] p);
        return (p == ALAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
        return (p == QLAST) ? '0 : p + 1'b1;
    endfunction

    assign w_fire  = r_req_valid & bus.imem_req_ready;
    assign w_rsp   = bus.imem_rsp_valid;
    assign w_redir = bus.redirect_valid;
    assign w_stale = (r_disc != '0);
    assign w_push  = w_rsp & ~w_stale & ~w_redir;
    assign w_pop   = (r_cnt != '0) & bus.instr_ready & ~w_redir;

    always_comb begin
        w_outs_n = r_outs + OW'(w_fire) - OW'(w_rsp);
        w_disc_n = r_disc - OW'(w_rsp & w_stale);
        w_cnt_n  = r_cnt + CW'(w_push) - CW'(w_pop);
        w_pc_n   = w_fire ? r_pc + 32'd4 : r_pc;
        if (w_redir) begin
            // everything still in flight after this edge is stale
            w_disc_n = w_outs_n;
            w_cnt_n  = '0;
            w_pc_n   = bus.redirect_pc & ~32'h3;
        end
        // credit: every live read in flight must find a free FIFO slot
        w_live_n = 32'(w_outs_n) - 32'(w_disc_n) + 32'(w_cnt_n);
        w_req_n  = (w_outs_n < MAXO_C) && (w_live_n < 32'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_outs      <= '0;
            r_disc      <= '0;
            r_cnt       <= '0;
            r_req_valid <= 1'b0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_qwr       <= '0;
            r_qrd       <= '0;
        end else begin
            r_pc        <= w_pc_n;
            r_outs      <= w_outs_n;
            r_disc      <= w_disc_n;
            r_cnt       <= w_cnt_n;
            r_req_valid <= w_req_n;
            if (w_fire) r_qwr <= qinc(r_qwr);
            if (w_rsp)  r_qrd <= qinc(r_qrd);
            if (w_redir) begin
                r_wr <= '0;
                r_rd <= '0;
            end else begin
                if (w_push) r_wr <= finc(r_wr);
                if (w_pop)  r_rd <= finc(r_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) r_qpc[r_qwr] <= r_pc;
        if (w_push) begin
            r_fdata[r_wr] <= bus.imem_rsp_data;
            r_fpc[r_wr]   <= r_qpc[r_qrd];
        end
    end

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr_valid    = (r_cnt != '0);
    assign bus.instr          = r_fdata[r_rd];
    assign bus.instr_pc       = r_fpc[r_rd];

    a_fifo_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && r_cnt == DEPTH_C));
    a_outs_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_fire && !w_rsp && r_outs == MAXO_C));
    a_outs_unf: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rsp && r_outs == '0));
    a_disc_le:  assert property (@(posedge clk) disable iff (!rst_n)
        r_disc <= r_outs);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random memory/decode/redirect traffic against a
// transaction-level model of the fetch stream, plus directed scenarios.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 2;
    localparam int MAXO  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC       (RESET_PC),
        .FIFO_DEPTH     (DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          live;
    } mreq_t;

    mreq_t mq[$];
    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          occ;
    bit          after_rst;
    bit          hold_req;
    bit          hold_ins;
    logic [31:0] h_addr;
    logic [31:0] h_ins;
    logic [31:0] h_ipc;

    int p_rsp  = 100;
    int p_mrdy = 100;
    int p_rdy  = 100;
    int p_redir = 0;
    bit hold_rsp   = 1'b0;
    bit rst_req    = 1'b0;
    bit combo_arm  = 1'b0;
    bit combo_done = 1'b0;
    bit f_redir    = 1'b0;
    logic [31:0] f_pc = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int lim);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout after %0d cycles", nm, lim);
    endtask

    // compare process: model state is the state before this cycle's edge
    always @(negedge clk) begin
        mreq_t e;
        int live;
        int o;
        bit fire, rsp, redir, acc;
        if (!rst_n) begin
            mq.delete();
            occ       = 0;
            exp_pc    = RESET_PC;
            exp_fetch = RESET_PC;
            after_rst = 1'b1;
            hold_req  = 1'b0;
            hold_ins  = 1'b0;
        end else begin
            fire  = bus.imem_req_valid && bus.imem_req_ready;
            rsp   = bus.imem_rsp_valid;
            redir = bus.redirect_valid;
            acc   = bus.instr_valid && bus.instr_ready;
            live  = 0;
            foreach (mq[i]) if (mq[i].live) live++;
            chk("req_addr", bus.imem_req_addr, exp_fetch);
            if (after_rst)
                chk("req_valid_rst", 32'(bus.imem_req_valid), 32'd0);
            else
                chk("req_valid", 32'(bus.imem_req_valid),
                    32'(mq.size() < MAXO && live + occ < DEPTH));
            chk("instr_valid", 32'(bus.instr_valid), 32'(occ > 0));
            if (hold_req) begin
                chk("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
                chk("req_hold_addr", bus.imem_req_addr, h_addr);
            end
            if (hold_ins) begin
                chk("head_hold_valid", 32'(bus.instr_valid), 32'd1);
                chk("head_hold_instr", bus.instr, h_ins);
                chk("head_hold_pc", bus.instr_pc, h_ipc);
            end
            if (acc && !redir) begin
                chk("instr_pc", bus.instr_pc, exp_pc);
                chk("instr", bus.instr, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            hold_req = bus.imem_req_valid && !bus.imem_req_ready && !redir;
            h_addr   = bus.imem_req_addr;
            hold_ins = bus.instr_valid && !bus.instr_ready && !redir;
            h_ins    = bus.instr;
            h_ipc    = bus.instr_pc;
            o = occ;
            if (rsp && mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live && !redir) occ++;
            end
            if (acc && !redir && o > 0) occ--;
            if (fire) begin
                mq.push_back('{addr: exp_fetch, live: 1'b1});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (mq.size() > MAXO) begin
                n_chk++;
                n_fail++;
                $display("FAIL outstanding: got %0d max %0d", mq.size(), MAXO);
            end
            if (redir) begin
                foreach (mq[i]) mq[i].live = 1'b0;
                occ       = 0;
                exp_pc    = bus.redirect_pc & ~32'h3;
                exp_fetch = exp_pc;
            end
            after_rst = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        rst_n = !rst_req;
        bus.imem_req_ready = ($urandom_range(99) < p_mrdy);
        bus.instr_ready    = ($urandom_range(99) < p_rdy);
        bus.imem_rsp_valid = rst_n && !hold_rsp && mq.size() > 0 &&
                             ($urandom_range(99) < p_rsp);
        bus.redirect_valid = rst_n && (f_redir || ($urandom_range(99) < p_redir));
        if (f_redir)
            bus.redirect_pc = f_pc;
        else if ($urandom_range(7) == 0)
            bus.redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else
            bus.redirect_pc = $urandom & 32'h0000_0FFF;
        if (combo_arm && rst_n && bus.imem_req_valid && mq.size() > 0) begin
            bus.imem_req_ready = 1'b1;
            bus.imem_rsp_valid = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 32'h0000_0400;
            combo_arm  = 1'b0;
            combo_done = 1'b1;
        end
        bus.imem_rsp_data = bus.imem_rsp_valid ? memf(mq[0].addr) : $urandom;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acc(input string nm, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            cyc();
            if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid)
                ok = 1'b1;
        end
        if (!ok) timeout(nm, lim);
    endtask

    initial begin
        bit ok;
        int cnt;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;

        rst_req = 1'b1;
        repeat (3) cyc();
        rst_req = 1'b0;
        cyc();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_addr", bus.imem_req_addr, 32'h0000_0000);

        wait_acc("t1_first", 20, ok);
        if (ok) begin
            chk("t1_first_pc", bus.instr_pc, 32'h0000_0000);
            chk("t1_first_instr", bus.instr, 32'h1234_5678);
        end
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (bus.instr_valid && bus.instr_ready) cnt++;
        end
        n_chk++;
        if (cnt < 18) begin
            n_fail++;
            $display("FAIL t1_throughput: got %0d accepts need >= 18", cnt);
        end

        p_rdy = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.imem_req_valid && bus.imem_req_ready) cnt++;
        end
        n_chk++;
        if (cnt > DEPTH + MAXO) begin
            n_fail++;
            $display("FAIL t2_reads: got %0d max %0d", cnt, DEPTH + MAXO);
        end
        chk("t2_valid", 32'(bus.instr_valid), 32'd1);
        p_rdy = 100;
        repeat (10) cyc();

        hold_rsp = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc();
            if (mq.size() == 2) ok = 1'b1;
        end
        if (!ok) timeout("t3_two_out", 20);
        f_redir = 1'b1;
        f_pc    = 32'h0000_0100;
        cyc();
        f_redir  = 1'b0;
        hold_rsp = 1'b0;
        wait_acc("t3_acc", 20, ok);
        if (ok) chk("t3_pc", bus.instr_pc, 32'h0000_0100);

        combo_arm  = 1'b1;
        combo_done = 1'b0;
        for (int i = 0; i < 30 && !combo_done; i++) cyc();
        if (!combo_done) begin
            combo_arm = 1'b0;
            timeout("t4_combo", 30);
        end
        cyc();
        chk("t4_valid", 32'(bus.instr_valid), 32'd0);
        wait_acc("t4_acc", 20, ok);
        if (ok) chk("t4_pc", bus.instr_pc, 32'h0000_0400);

        f_redir = 1'b1;
        f_pc    = 32'h0000_0203;
        cyc();
        f_redir = 1'b0;
        cyc();
        chk("t5_align", bus.imem_req_addr, 32'h0000_0200);
        f_redir = 1'b1;
        f_pc    = 32'hFFFF_FFFC;
        cyc();
        f_redir = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc();
            if (bus.imem_req_addr != 32'hFFFF_FFFC) ok = 1'b1;
        end
        if (ok) chk("t5_wrap", bus.imem_req_addr, 32'h0000_0000);
        else timeout("t5_wrap", 20);
        repeat (10) cyc();

        p_rdy = 0;
        repeat (8) cyc();
        chk("t6_full", 32'(bus.instr_valid), 32'd1);
        rst_req = 1'b1;
        cyc();
        rst_req = 1'b0;
        cyc();
        chk("t6_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("t6_addr", bus.imem_req_addr, 32'h0000_0000);
        chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd0);
        p_rdy = 100;

        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                p_rsp   = 30 + $urandom_range(70);
                p_mrdy  = 30 + $urandom_range(70);
                p_rdy   = 20 + $urandom_range(80);
                p_redir = $urandom_range(10);
            end
            rst_req = (i % 997 == 500);
            cyc();
        end
        rst_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
